bin_to_bcd_seq: RTL and testbench
=================================

// Module: bin_to_bcd_seq
// PURPOSE
// - Sequential binary-to-BCD converter (shift-add-3 / double dabble), one bit per clock.
// - Sits directly upstream of driver_7_seg: BCD_out connects to its BCD_in, so displays show decimal, not hex.
// - Holds the last result stable while a new conversion runs, so the multiplexed displays never show partial values.
// PARAMETERS
// - N_BIN  16  width of binary input; 1..27.
// - N_DIG  5   BCD digits produced; must satisfy 10**N_DIG > 2**N_BIN-1 and 4*N_DIG <= 32.
//   Violation -> elaboration-time $error.
// PORTS
// - clock    in   1        system clock, rising edge.
// - reset    in   1        asynchronous, active-low reset.
// - start    in   1        conversion request, sampled only in IDLE.
// - bin_in   in   N_BIN    binary value, latched on accepted start.
// - busy     out  1        high while converting.
// - done     out  1        one-cycle pulse when BCD_out updates.
// - neg      out  1        sign of last result (SIGNED_INPUT_EN only; else 0).
// - BCD_out  out  4*N_DIG  packed BCD, digit 0 in [3:0]; feeds driver_7_seg BCD_in.
// BEHAVIOUR
// - Reset (reset=0, async), held until release:
//   - busy=0, done=0, neg=0, BCD_out=0, state=IDLE.
//   - All internal shift/scratch/counter registers cleared.
// - FSM states: IDLE, SHIFT, FINISH.
// - IDLE:
//   - start=1 at edge k -> latch operand into shift reg, clear scratch BCD, bit counter=N_BIN, go SHIFT.
//   - busy=1 from edge k.
// - SHIFT, each edge:
//   - Every scratch digit >=5 gets +3 (combinational adjust).
//   - Then {scratch, shift} shifted left 1, counter decrements.
//   - Counter reaching 0 at edge k+N_BIN -> go FINISH.
// - FINISH, edge k+N_BIN+1:
//   - BCD_out<=scratch, neg<=latched sign, done=1 for that cycle only.
//   - busy=0, go IDLE.
// - Latency: done high exactly N_BIN+1 cycles after the accepting edge.
//   Back-to-back: next start accepted on the edge done is high (FINISH->IDLE edge is next).
// - start while busy=1 or in FINISH: ignored, no queuing.
// - bin_in changes after acceptance: no effect on the running conversion.
// - BCD_out, neg: change only in FINISH; constant otherwise.
// - Scratch width 4*N_DIG; adjust never overflows a digit given the parameter constraint.
// - Reset mid-conversion: conversion aborted, BCD_out cleared to 0, no done pulse.
// CONFIGURATION
// - Macro SIGNED_INPUT_EN.
// - Defined:
//   - bin_in is two's complement.
//   - At accept: sign latched, operand = magnitude (|bin_in|, N_BIN-bit unsigned; -2**(N_BIN-1) -> 2**(N_BIN-1)).
//   - neg=sign in FINISH; neg=0 for zero.
//   - N_DIG constraint checked against 2**(N_BIN-1).
// - Undefined:
//   - bin_in unsigned, neg tied 0, no sign/negate logic synthesized.
// TESTING (N_BIN=16, N_DIG=5)
// - T1: reset low mid-run, then release -> BCD_out=0, busy=0, done=0; start 16'd0 -> done after 17 cycles, BCD_out=20'h00000.
// - T2: unsigned start 16'd65535 -> BCD_out=20'h65535, done single pulse 17 cycles after accept, busy high 17 cycles.
// - T3: start 16'd12345, then start 16'd999 every cycle while busy -> result 20'h12345, exactly one done.
//   Then start 16'd999 -> 20'h00999, BCD_out held at 20'h12345 until that done.
// - T4: start 16'd4321, assert reset at cycle 8 -> BCD_out=0, no done.
//   Restart 16'd4321 -> 20'h04321.
// - T5 (SIGNED_INPUT_EN): 16'hFFFF -> neg=1, 20'h00001; 16'h8000 -> neg=1, 20'h32768; 16'h7FFF -> neg=0, 20'h32767.
// - T6: randomized 1000 values vs reference model; checks:
//   - BCD_out == decimal(bin_in);
//   - every digit <= 9;
//   - done occurs exactly N_BIN+1 cycles after each accept.

Source files
------------

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter, shift-add-3, one bit per clock.
// Define SIGNED_INPUT_EN for two's complement input with sign-magnitude output.
module bin_to_bcd_seq #(
  parameter int N_BIN = 16,
  parameter int N_DIG = 5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [N_BIN-1:0]   bin_in,
  output logic               busy,
  output logic               done,
  output logic               neg,
  output logic [4*N_DIG-1:0] BCD_out
);

  localparam int W  = 4 * N_DIG;
  localparam int CW = $clog2(N_BIN + 1);
`ifdef SIGNED_INPUT_EN
  localparam longint MAXV = longint'(1) << (N_BIN - 1);
`else
  localparam longint MAXV = (longint'(1) << N_BIN) - 1;
`endif
  localparam longint DECV = longint'(10) ** N_DIG;

  generate
    if (N_BIN < 1 || N_BIN > 27 || W > 32 || DECV <= MAXV) begin : g_bad
      $error("bin_to_bcd_seq: illegal N_BIN/N_DIG");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FINISH
  } state_t;

  state_t           state, state_nx;
  logic [N_BIN-1:0] shreg;
  logic [W-1:0]     scr;
  logic [W-1:0]     scr_adj;
  logic [CW-1:0]    cnt;
  logic [N_BIN-1:0] operand;
  logic             accept;

  assign accept = (state == IDLE) && start;

`ifdef SIGNED_INPUT_EN
  logic sign_in;
  logic sign_q;

  assign sign_in = bin_in[N_BIN-1];
  // Negating -2**(N_BIN-1) wraps to itself, which is its magnitude.
  assign operand = sign_in ? (~bin_in + 1'b1) : bin_in;
`else
  assign operand = bin_in;
`endif

  always_comb begin
    scr_adj = scr;
    for (int i = 0; i < N_DIG; i++) begin
      if (scr[4*i +: 4] >= 4'd5) begin
        scr_adj[4*i +: 4] = scr[4*i +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = SHIFT;
      SHIFT:   if (cnt == CW'(1)) state_nx = FINISH;
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      shreg   <= '0;
      scr     <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      BCD_out <= '0;
    end else begin
      busy <= (state_nx != IDLE);
      done <= (state == FINISH);
      if (accept) begin
        shreg <= operand;
        scr   <= '0;
        cnt   <= CW'(N_BIN);
      end else if (state == SHIFT) begin
        {scr, shreg} <= {scr_adj, shreg} << 1;
        cnt          <= cnt - CW'(1);
      end
      if (state == FINISH) begin
        BCD_out <= scr;
      end
    end
  end

`ifdef SIGNED_INPUT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sign_q <= 1'b0;
      neg    <= 1'b0;
    end else begin
      if (accept) sign_q <= sign_in;
      if (state == FINISH) neg <= sign_q;
    end
  end
`else
  assign neg = 1'b0;
`endif

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed and random bench for bin_to_bcd_seq (N_BIN=16, N_DIG=5).
module tb_bin_to_bcd_seq;

  logic        clock;
  logic        reset;
  logic        start;
  logic [15:0] bin_in;
  logic        busy;
  logic        done;
  logic        neg;
  logic [19:0] BCD_out;

  int checks;
  int errors;

  bin_to_bcd_seq #(.N_BIN(16), .N_DIG(5)) dut (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .bin_in (bin_in),
    .busy   (busy),
    .done   (done),
    .neg    (neg),
    .BCD_out(BCD_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [19:0] to_bcd(input int unsigned m);
    logic [19:0] r;
    int unsigned v;
    r = '0;
    v = m;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Starts one conversion; returns done latency and busy-high cycle count.
  task automatic convert(input logic [15:0] v, output int lat,
                         output int busy_n);
    @(negedge clock);
    bin_in = v;
    start  = 1'b1;
    @(negedge clock);
    start  = 1'b0;
    busy_n = busy ? 1 : 0;
    lat    = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clock);
      if (done) begin
        lat = n;
        break;
      end
      if (busy) busy_n++;
    end
  endtask

  task automatic test_reset;
    int lat, bn;
    @(negedge clock);
    bin_in = 16'd777;
    start  = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (5) @(negedge clock);
    reset = 1'b0;
    #1;
    checks++;
    if (BCD_out !== 20'h0 || busy !== 1'b0 || done !== 1'b0 || neg !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: bcd=%h busy=%b done=%b neg=%b want 0 0 0 0",
               BCD_out, busy, done, neg);
    end
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (BCD_out !== 20'h0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: bcd=%h busy=%b done=%b want 0 0 0",
               BCD_out, busy, done);
    end
    convert(16'd0, lat, bn);
    checks++;
    if (lat !== 17) begin
      errors++;
      $display("FAIL zero_latency: got %0d want 17", lat);
    end
    checks++;
    if (BCD_out !== 20'h00000) begin
      errors++;
      $display("FAIL zero_value: got %h want 00000", BCD_out);
    end
  endtask

  task automatic test_max;
    int lat, bn;
    convert(16'd65535, lat, bn);
    checks++;
    if (lat !== 17) begin
      errors++;
      $display("FAIL max_latency: got %0d want 17", lat);
    end
    checks++;
    if (bn !== 17) begin
      errors++;
      $display("FAIL max_busy_cycles: got %0d want 17", bn);
    end
`ifndef SIGNED_INPUT_EN
    checks++;
    if (BCD_out !== 20'h65535 || neg !== 1'b0) begin
      errors++;
      $display("FAIL max_value: got %h neg=%b want 65535 neg=0", BCD_out, neg);
    end
`endif
    @(negedge clock);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse_width: done=%b want 0", done);
    end
  endtask

  task automatic test_ignore;
    int dn, lat, held_bad;
    logic [19:0] prev;
    prev = BCD_out;
    @(negedge clock);
    bin_in = 16'd12345;
    start  = 1'b1;
    @(negedge clock);
    bin_in   = 16'd999;
    dn       = 0;
    lat      = -1;
    held_bad = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clock);
      if (done) begin
        lat   = n;
        start = 1'b0;
        break;
      end
      if (BCD_out !== prev) held_bad++;
    end
    checks++;
    if (lat !== 17 || BCD_out !== 20'h12345) begin
      errors++;
      $display("FAIL ignore_result: lat=%0d bcd=%h want 17 12345", lat, BCD_out);
    end
    checks++;
    if (held_bad !== 0) begin
      errors++;
      $display("FAIL ignore_hold: %0d changed cycles want 0", held_bad);
    end
    if (lat > 0) dn = 1;
    repeat (25) begin
      @(negedge clock);
      if (done) dn++;
    end
    checks++;
    if (dn !== 1) begin
      errors++;
      $display("FAIL ignore_single_done: got %0d want 1", dn);
    end
    @(negedge clock);
    bin_in = 16'd999;
    start  = 1'b1;
    @(negedge clock);
    start    = 1'b0;
    lat      = -1;
    held_bad = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clock);
      if (done) begin
        lat = n;
        break;
      end
      if (BCD_out !== 20'h12345) held_bad++;
    end
    checks++;
    if (lat !== 17 || BCD_out !== 20'h00999 || held_bad !== 0) begin
      errors++;
      $display("FAIL b2b_999: lat=%0d bcd=%h held_bad=%0d want 17 00999 0",
               lat, BCD_out, held_bad);
    end
  endtask

  task automatic test_abort;
    int dn, lat, bn;
    @(negedge clock);
    bin_in = 16'd4321;
    start  = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (8) @(negedge clock);
    reset = 1'b0;
    #1;
    checks++;
    if (BCD_out !== 20'h0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_state: bcd=%h busy=%b done=%b want 0 0 0",
               BCD_out, busy, done);
    end
    @(negedge clock);
    reset = 1'b1;
    dn = 0;
    repeat (20) begin
      @(negedge clock);
      if (done) dn++;
    end
    checks++;
    if (dn !== 0 || BCD_out !== 20'h0) begin
      errors++;
      $display("FAIL abort_no_done: dones=%0d bcd=%h want 0 00000", dn, BCD_out);
    end
    convert(16'd4321, lat, bn);
    checks++;
    if (lat !== 17 || BCD_out !== 20'h04321) begin
      errors++;
      $display("FAIL abort_restart: lat=%0d bcd=%h want 17 04321", lat, BCD_out);
    end
  endtask

`ifdef SIGNED_INPUT_EN
  task automatic test_signed;
    int lat, bn;
    logic [15:0] v [3];
    logic [19:0] e [3];
    logic        s [3];
    v[0] = 16'hFFFF; e[0] = 20'h00001; s[0] = 1'b1;
    v[1] = 16'h8000; e[1] = 20'h32768; s[1] = 1'b1;
    v[2] = 16'h7FFF; e[2] = 20'h32767; s[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      convert(v[i], lat, bn);
      checks++;
      if (lat !== 17 || BCD_out !== e[i] || neg !== s[i]) begin
        errors++;
        $display("FAIL signed_%h: lat=%0d bcd=%h neg=%b want 17 %h %b",
                 v[i], lat, BCD_out, neg, e[i], s[i]);
      end
    end
  endtask
`endif

  task automatic test_random;
    int lat, bn, bad_val, bad_dig, bad_lat;
    logic [15:0] v;
    logic [19:0] e;
    logic        s;
    int unsigned m;
    bad_val = 0;
    bad_dig = 0;
    bad_lat = 0;
    for (int i = 0; i < 1000; i++) begin
      v = 16'($urandom);
`ifdef SIGNED_INPUT_EN
      s = v[15];
      m = s ? (32'd65536 - 32'(v)) : 32'(v);
`else
      s = 1'b0;
      m = 32'(v);
`endif
      e = to_bcd(m);
      convert(v, lat, bn);
      if (lat != 17) bad_lat++;
      if (BCD_out !== e || neg !== s) begin
        bad_val++;
        if (bad_val <= 5)
          $display("FAIL rand_value: in=%h got %h neg=%b want %h neg=%b",
                   v, BCD_out, neg, e, s);
      end
      for (int d = 0; d < 5; d++) begin
        if (BCD_out[4*d +: 4] > 4'd9) bad_dig++;
      end
    end
    checks++;
    if (bad_val !== 0) begin
      errors++;
      $display("FAIL rand_values: %0d wrong want 0", bad_val);
    end
    checks++;
    if (bad_dig !== 0) begin
      errors++;
      $display("FAIL rand_digits: %0d digits >9 want 0", bad_dig);
    end
    checks++;
    if (bad_lat !== 0) begin
      errors++;
      $display("FAIL rand_latency: %0d wrong want 0", bad_lat);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    start  = 1'b0;
    bin_in = '0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    test_reset;
    test_max;
    test_ignore;
    test_abort;
`ifdef SIGNED_INPUT_EN
    test_signed;
`endif
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
